// File: rtl/tt_um_pwm_capture_jmkr_pkg.sv
// Shared types and constants for the PWM capture block: FSM states,
// result-byte select codes, counter width and status bit positions.
package tt_um_pwm_capture_jmkr_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_e;

  localparam logic [1:0] SEL_HIGH_LO = 2'd0;
  localparam logic [1:0] SEL_HIGH_HI = 2'd1;
  localparam logic [1:0] SEL_PER_LO  = 2'd2;
  localparam logic [1:0] SEL_PER_HI  = 2'd3;

  localparam int STAT_VALID = 0;
  localparam int STAT_OVF   = 1;
  localparam int STAT_LEVEL = 2;

  localparam logic [7:0] UIO_OE_VAL = 8'b0000_0111;

endpackage

// File: rtl/tt_um_pwm_capture_jmkr_sync_edge.sv
// Multi-flop synchronizer for the asynchronous PWM input followed by a
// one-flop edge detector; rise/fall are single-cycle pulses.
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/tt_um_pwm_capture_jmkr.sv
// PWM capture: measures high time and period of pwm_in in clk cycles between
// consecutive synchronized rises and exposes the latched result bytewise.
module tt_um_pwm_capture_jmkr
  import tt_um_pwm_capture_jmkr_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic       pwm_in, clr, level, rise, fall;
  logic [1:0] rd_sel;

  assign pwm_in = ui_in[0];
  assign rd_sel = ui_in[2:1];
  assign clr    = ui_in[3];

  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in[7:4], uio_in};

  pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (pwm_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d, pcnt_q, pcnt_d;
  logic [CNT_W-1:0]   high_q, high_d, per_q, per_d;
  logic               valid_q, valid_d, ovf_q, ovf_d;
  logic               pcnt_max;

  assign pcnt_max = (pcnt_q == {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hcnt_q  <= '0;
      pcnt_q  <= '0;
      high_q  <= '0;
      per_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      pcnt_q  <= pcnt_d;
      high_q  <= high_d;
      per_q   <= per_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // Priority: clr, then ena, then the measurement FSM.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    pcnt_d  = pcnt_q;
    high_d  = high_q;
    per_d   = per_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (clr) begin
      state_d = ST_ARM;
      hcnt_d  = '0;
      pcnt_d  = '0;
      high_d  = '0;
      per_d   = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (!ena) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM: begin
          if (rise) begin
            state_d = ST_HIGH;
            hcnt_d  = CNT_W'(1);
            pcnt_d  = CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (pcnt_max) begin
            ovf_d   = 1'b1;
            state_d = ST_ARM;
          end else begin
            pcnt_d = pcnt_q + CNT_W'(1);
            if (fall) state_d = ST_LOW;
            else      hcnt_d  = hcnt_q + CNT_W'(1);
          end
        end
        ST_LOW: begin
          // The closing rise also opens the next period.
          if (rise) begin
            high_d  = hcnt_q;
            per_d   = pcnt_q;
            valid_d = 1'b1;
            state_d = ST_HIGH;
            hcnt_d  = CNT_W'(1);
            pcnt_d  = CNT_W'(1);
          end else if (pcnt_max) begin
            ovf_d   = 1'b1;
            state_d = ST_ARM;
          end else begin
            pcnt_d = pcnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    uo_out = high_q[7:0];
    case (rd_sel)
      SEL_HIGH_LO: uo_out = high_q[7:0];
      SEL_HIGH_HI: uo_out = high_q[15:8];
      SEL_PER_LO:  uo_out = per_q[7:0];
      SEL_PER_HI:  uo_out = per_q[15:8];
      default:     uo_out = high_q[7:0];
    endcase
  end

  always_comb begin
    uio_out             = 8'h00;
    uio_out[STAT_VALID] = valid_q;
    uio_out[STAT_OVF]   = ovf_q;
    uio_out[STAT_LEVEL] = level;
  end

  assign uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_pwm_capture_jmkr.sv
// Directed and randomized bench for the PWM capture block; expected results
// come from the pulse lengths the bench itself drives.
module tb_tt_um_pwm_capture_jmkr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       pwm = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] rd_sel = 2'd0;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] ui_in, uo_out, uio_out, uio_oe;

  assign ui_in = {4'b0000, clr, rd_sel, pwm};

  tt_um_pwm_capture_jmkr #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Input held high for h cycles then low for l cycles, changes on negedge.
  task automatic pulse(input int h, input int l);
    pwm = 1'b1;
    repeat (h) @(negedge clk);
    pwm = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic read_res(output logic [15:0] hc, output logic [15:0] pc);
    rd_sel = 2'd0; #1 hc[7:0]  = uo_out;
    rd_sel = 2'd1; #1 hc[15:8] = uo_out;
    rd_sel = 2'd2; #1 pc[7:0]  = uo_out;
    rd_sel = 2'd3; #1 pc[15:8] = uo_out;
  endtask

  task automatic check_result(input string tag, input logic [15:0] h, input logic [15:0] p,
                              input logic [7:0] st);
    logic [15:0] hc, pc;
    read_res(hc, pc);
    check({tag, "_high"}, {16'h0, hc}, {16'h0, h});
    check({tag, "_period"}, {16'h0, pc}, {16'h0, p});
    check({tag, "_status"}, {24'h0, uio_out}, {24'h0, st});
  endtask

  initial begin
    logic [7:0]  eb [4];
    logic [31:0] e;
    int          h, l;

    // reset state
    uio_in = 8'h5A;
    ena    = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      rd_sel = 2'(s);
      #1 check("rst_uo", {24'h0, uo_out}, 32'h0);
    end
    check("rst_uio_out", {24'h0, uio_out}, 32'h0);
    check("rst_uio_oe", {24'h0, uio_oe}, 32'h07);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 3 high / 5 low: result visible 3 cycles after the second rise
    pulse(3, 5);
    pulse(3, 5);
    pwm = 1'b1;
    repeat (3) @(negedge clk);
    eb[0] = 8'h03; eb[1] = 8'h00; eb[2] = 8'h08; eb[3] = 8'h00;
    for (int s = 0; s < 4; s++) begin
      rd_sel = 2'(s);
      #1 check("p3_5_byte", {24'h0, uo_out}, {24'h0, eb[s]});
    end
    check("p3_5_status", {24'h0, uio_out}, 32'h05);
    pwm = 1'b0;
    repeat (5) @(negedge clk);

    // 300 high / 700 low
    pulse(300, 700);
    pulse(300, 700);
    check_result("p300_700", 16'h012C, 16'h03E8, 8'h01);

    // clear, then randomized periods against the pulse-length model
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_result("clr", 16'h0, 16'h0, 8'h00);
    for (int i = 0; i < 12; i++) begin
      h = $urandom_range(40, 1);
      l = $urandom_range(40, 3);
      pulse(h, l);
      if (i > 0) begin
        e = exp_q.pop_front();
        check_result("rand", e[31:16], e[15:0], 8'h01);
      end
      exp_q.push_back({16'(h), 16'(h + l)});
    end
    exp_q.delete();

    // clr coincident with the synchronized rise
    pwm = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_result("clr_rise", 16'h0, 16'h0, 8'h04);
    repeat (3) @(negedge clk);
    pwm = 1'b0;
    repeat (5) @(negedge clk);
    pulse(5, 9);
    check_result("clr_arm_only", 16'h0, 16'h0, 8'h00);
    pulse(7, 4);
    check_result("clr_next", 16'd5, 16'd14, 8'h01);

    // reset mid-period
    pulse(4, 3);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_result("rst_mid", 16'h0, 16'h0, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    pulse(6, 6);
    check_result("rst_first_rise", 16'h0, 16'h0, 8'h00);
    pulse(8, 3);
    check_result("rst_second_rise", 16'd6, 16'd12, 8'h01);

    // ena dropped mid-period
    pwm = 1'b1;
    repeat (5) @(negedge clk);
    ena = 1'b0;
    repeat (5) @(negedge clk);
    pwm = 1'b0;
    repeat (5) @(negedge clk);
    check_result("ena_hold", 16'd8, 16'd11, 8'h01);
    ena = 1'b1;
    repeat (4) @(negedge clk);
    pulse(9, 5);
    check_result("ena_rearm", 16'd8, 16'd11, 8'h01);
    pulse(3, 3);
    check_result("ena_resume", 16'd9, 16'd14, 8'h01);

    // single-cycle high pulses
    pulse(1, 6);
    pulse(1, 6);
    check_result("glitch_a", 16'd1, 16'd7, 8'h01);
    pulse(2, 4);
    check_result("glitch_b", 16'd1, 16'd7, 8'h01);

    // constant high ends in overflow with no new result
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    pwm = 1'b1;
    repeat (70000) @(negedge clk);
    check_result("ovf", 16'h0, 16'h0, 8'h06);
    pwm = 1'b0;
    repeat (5) @(negedge clk);
    check_result("ovf_sticky", 16'h0, 16'h0, 8'h02);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
